xor_net_arbiter: RTL and testbench
==================================

# xor_net_arbiter

Round-robin arbiter and scheduler that shares one `xor_net` instance between `NUM_REQ` independent requesters. Each requester presents a two-input sample with a valid/ready handshake. The arbiter issues samples to the network one per handshake and records the requester ID of each issued sample in an in-order tag FIFO. It then routes every network result back to the requester that issued it. A drain control stops new issues and reports when the network is empty; it is used before weight reconfiguration.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `TAG_DEPTH`, 8, maximum outstanding samples in the network; power of two, ≥2.
- `DATA_WIDTH`, package constant `cnn1d_pkg::DATA_WIDTH` (12), sample and result width; not overridable.
- `clk` input, 1, sole clock; all state updates on the rising edge.
- `rst` input, 1, asynchronous, active-low reset.
- `req_valid` input, [NUM_REQ-1:0], requester has a sample.
- `req_ready` output, [NUM_REQ-1:0], sample accepted this cycle.
- `req_data` input, [DATA_WIDTH-1:0] [0:NUM_REQ-1][0:1], two network inputs per requester.
- `rsp_valid` output, [NUM_REQ-1:0], result available for requester i.
- `rsp_ready` input, [NUM_REQ-1:0], requester i accepts its result.
- `rsp_data` output, [DATA_WIDTH-1:0], result; shared by all requesters.
- `net_valid_in` output, [1:0], drives `xor_net_valid_in`; both bits always equal.
- `net_ready_in` input, [1:0], from `xor_net_ready_in`.
- `net_data_in` output, [DATA_WIDTH-1:0] [0:1], drives `xor_net_data_in`.
- `net_valid_out` input, 1, from `xor_net_valid_out`.
- `net_ready_out` output, 1, drives `xor_net_ready_out`.
- `net_data_out` input, [DATA_WIDTH-1:0], from `xor_net_data_out`.
- `drain_req` input, 1, level request to stop issuing new samples.
- `drain_done` output, 1, drain state entered and no samples outstanding.
- `outstanding` output, [$clog2(TAG_DEPTH):0], current tag FIFO occupancy.
- `err_orphan` output, 1, sticky flag: network produced a result while the tag FIFO was empty.

## Operation
**Arbitration (combinational)**
- Priority pointer `ptr` is a register, reset to 0.
- Grant `g` is the first index i, searching `ptr`, `ptr+1`, … modulo `NUM_REQ`, with `req_valid[i]=1`.
- `can_issue` = (state==RUN) && any `req_valid` && tag FIFO not full.
- `net_valid_in` = {2{can_issue}}.
- `net_data_in` = `req_data[g]`.
- `req_ready[i]` = `can_issue` && (i==g) && `&net_ready_in`.

**Issue**
- An issue occurs when `can_issue` && `&net_ready_in`.
- On issue: push `g` into the tag FIFO, and set `ptr` ← (g+1) mod `NUM_REQ`.
- `ptr` is unchanged on cycles with no issue.

**Return path**
- `h` = tag FIFO head.
- `rsp_valid[h]` = `net_valid_out` && FIFO not empty; all other `rsp_valid` bits are 0.
- `rsp_data` = `net_data_out`.
- `net_ready_out` = FIFO not empty && `rsp_ready[h]`.
- Pop on `net_valid_out` && `net_ready_out`.

**Push/pop boundaries**
- Simultaneous push and pop: occupancy is unchanged.
- When full, a push is blocked even if a pop occurs in the same cycle. `can_issue` is evaluated on the registered occupancy only.

**Orphan results**
- `net_valid_out` with the FIFO empty: `net_ready_out` = 0 (the result stalls in the network), and `err_orphan` is set. It stays set until reset.

**FSM, 2 states, reset to RUN**
- RUN → DRAIN when `drain_req`=1.
- DRAIN → RUN when `drain_req`=0.
- In DRAIN, no issues occur; returns continue.
- `drain_done` = (state==DRAIN) && `outstanding`==0.

## Timing
- Issue path is zero-latency combinational. Requester sample to `net_data_in` is in the same cycle.
- Return path is zero-latency combinational.
- A pushed tag becomes visible at the FIFO head the next cycle. The network latency must therefore be ≥1 cycle; `xor_net` satisfies this.
- Sustained throughput is one issue per cycle while the network is ready and the FIFO is not full.
- Reset values: `ptr`=0, FIFO empty, `outstanding`=0, `err_orphan`=0, state RUN.
- Outputs in reset: `net_valid_in`=0, `rsp_valid`=0, `net_ready_out`=0, `drain_done`=0. `req_ready`=0.
- Reset asserted mid-operation discards all tags. Results still in flight in the network become orphans unless the network is reset together with the arbiter, which it must be at system level.
- `drain_req` rising: the first blocked issue is in the cycle after the state register updates. The issue in the same cycle `drain_req` rises is still allowed.

## Structure
- Add to `cnn1d_pkg`: `typedef enum logic {ARB_RUN, ARB_DRAIN} xor_net_arb_state_t`.
- Sub-module `tag_fifo`: synchronous FIFO with `WIDTH`=$clog2(NUM_REQ), depth `TAG_DEPTH`, and async active-low reset.
  - Pointers wrap modulo `TAG_DEPTH`.
  - Count output drives `outstanding`.
  - Exposes `full`, `empty` and the head word.
- Round-robin search is a function in the arbiter body, not a separate module.

## Test plan
Bench uses a stub network with fixed latency 3 that returns in0+in1.
- **Single requester:** requester 2 sends {0x200,0x000} → one issue, then `rsp_valid[2]` 3 cycles later with `rsp_data`=0x200; other `rsp_valid` bits stay 0.
- **Fairness:** all 4 requesters hold valid for 8 issues → grant order 0,1,2,3,0,1,2,3; each response routes to its issuer in the same order.
- **Full FIFO:** stub never returns and issues continue → exactly 8 issues, then `req_ready`=0 and `outstanding`=8. Release the stub → 8 responses, then issuing resumes.
- **Backpressure:** `rsp_ready[h]`=0 for 5 cycles with a result pending → `net_ready_out`=0 and no pop. Raise `rsp_ready[h]` → pop in that cycle.
- **Drain:** assert `drain_req` with 3 outstanding → no further issues; `drain_done`=1 one cycle after the third response. Deassert → RUN, issuing resumes.
- **Orphan and reset:** force `net_valid_out` with the FIFO empty → `err_orphan`=1, sticky. Assert `rst` → all outputs return to their reset values immediately, asynchronously.

Source files
------------

// File: rtl/cnn1d_pkg.sv
// Shared constants and types for the 1-D CNN datapath blocks.
package cnn1d_pkg;

   localparam int DATA_WIDTH = 12;

   typedef enum logic {ARB_RUN, ARB_DRAIN} xor_net_arb_state_t;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester IDs for samples currently inside the network.
module tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A push while full is dropped even if a pop frees a slot in the same cycle.
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/xor_net_arbiter.sv
// Round-robin scheduler sharing one xor_net between NUM_REQ requesters,
// routing each network result back to its issuer via an in-order tag FIFO.
module xor_net_arbiter
   import cnn1d_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int TAG_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [DATA_WIDTH-1:0]       req_data [0:NUM_REQ-1][0:1],
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [DATA_WIDTH-1:0]       rsp_data,
   output logic [1:0]                  net_valid_in,
   input  logic [1:0]                  net_ready_in,
   output logic [DATA_WIDTH-1:0]       net_data_in [0:1],
   input  logic                        net_valid_out,
   output logic                        net_ready_out,
   input  logic [DATA_WIDTH-1:0]       net_data_out,
   input  logic                        drain_req,
   output logic                        drain_done,
   output logic [$clog2(TAG_DEPTH):0]  outstanding,
   output logic                        err_orphan,
   output xor_net_arb_state_t          state_dbg
);

   localparam int TAG_W = $clog2(NUM_REQ);

   xor_net_arb_state_t state;
   xor_net_arb_state_t state_nxt;
   logic [TAG_W-1:0]   ptr;
   logic [TAG_W-1:0]   grant;
   logic [TAG_W-1:0]   head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               can_issue;
   logic               issue;
   logic               pop;

   // First requester with valid set, searching from start upward modulo NUM_REQ.
   function automatic logic [TAG_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [TAG_W-1:0]   start);
      logic [TAG_W-1:0] pick;
      logic [TAG_W-1:0] idx;
      pick = start;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = TAG_W'((int'(start) + k) % NUM_REQ);
         if (valid[idx]) pick = idx;
      end
      return pick;
   endfunction

   // Every channel transfers on a cycle where valid and ready are both high;
   // valid never waits on ready, and data is meaningful only while valid is high.
   assign grant          = rr_pick(req_valid, ptr);
   assign can_issue      = rst && (state == ARB_RUN) && (|req_valid) && !fifo_full;
   assign issue          = can_issue && (&net_ready_in);
   assign net_valid_in   = {2{can_issue}};
   assign net_data_in[0] = req_data[grant][0];
   assign net_data_in[1] = req_data[grant][1];

   always_comb begin
      req_ready        = '0;
      req_ready[grant] = issue;
   end

   // Results are steered by the oldest tag; with no tag the result is held in the network.
   always_comb begin
      rsp_valid       = '0;
      rsp_valid[head] = net_valid_out && !fifo_empty;
   end

   assign rsp_data      = net_data_out;
   assign net_ready_out = !fifo_empty && rsp_ready[head];
   assign pop           = net_valid_out && net_ready_out;
   assign state_dbg     = state;

   tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (issue),
      .push_data (grant),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outstanding)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ARB_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      drain_done = 1'b0;
      case (state)
         ARB_RUN: begin
            if (drain_req) state_nxt = ARB_DRAIN;
         end
         ARB_DRAIN: begin
            if (!drain_req) state_nxt = ARB_RUN;
            drain_done = (outstanding == '0);
         end
         default: state_nxt = ARB_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr        <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (issue) ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
         if (net_valid_out && fifo_empty) err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_xor_net_arbiter.sv
// Bench for xor_net_arbiter: latency-3 adder stub network, per-requester sources,
// expected-issue and expected-response queues checked by a negedge monitor.
module tb_xor_net_arbiter;
   import cnn1d_pkg::*;

   localparam int NUM_REQ   = 4;
   localparam int TAG_DEPTH = 8;
   localparam int DW        = DATA_WIDTH;
   localparam int CW        = $clog2(TAG_DEPTH) + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic [NUM_REQ-1:0]  req_valid;
   logic [NUM_REQ-1:0]  req_ready;
   logic [DW-1:0]       req_data [0:NUM_REQ-1][0:1];
   logic [NUM_REQ-1:0]  rsp_valid;
   logic [NUM_REQ-1:0]  rsp_ready;
   logic [DW-1:0]       rsp_data;
   logic [1:0]          net_valid_in;
   logic [1:0]          net_ready_in;
   logic [DW-1:0]       net_data_in [0:1];
   logic                net_valid_out;
   logic                net_ready_out;
   logic [DW-1:0]       net_data_out;
   logic                drain_req;
   logic                drain_done;
   logic [CW-1:0]       outstanding;
   logic                err_orphan;
   xor_net_arb_state_t  state_dbg;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   xor_net_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .TAG_DEPTH (TAG_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_data      (req_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .net_valid_in  (net_valid_in),
      .net_ready_in  (net_ready_in),
      .net_data_in   (net_data_in),
      .net_valid_out (net_valid_out),
      .net_ready_out (net_ready_out),
      .net_data_out  (net_data_out),
      .drain_req     (drain_req),
      .drain_done    (drain_done),
      .outstanding   (outstanding),
      .err_orphan    (err_orphan),
      .state_dbg     (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   logic [15:0]   exp_q[$];               // {id, result}
   logic [27:0]   exp_iss_q[$];           // {id, in0, in1}
   logic [23:0]   src_q [NUM_REQ][$];     // {in0, in1} per requester
   logic [DW-1:0] net_res_q[$];
   int            net_t_q[$];
   int            n_cmp;
   int            n_err;
   int            cyc;
   int            issue_cnt;
   int            rsp_cnt;
   int            last_issue_cyc;
   int            last_rsp_cyc;

   logic               net_hold;
   logic               force_orphan;
   logic               stub_valid;
   logic [DW-1:0]      stub_data;
   logic [NUM_REQ-1:0] hs_req;
   logic               hs_in;
   logic               hs_out;
   logic [DW-1:0]      hs_sum;

   assign net_valid_out = force_orphan || stub_valid;
   assign net_data_out  = force_orphan ? 12'hABC : stub_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_iss_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check(name, 32'(exp_q.size() + exp_iss_q.size()), 0);
   endtask

   task automatic add_sample(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] s;
      s = a + b;
      src_q[id].push_back({a, b});
      exp_iss_q.push_back({4'(id), a, b});
      exp_q.push_back({4'(id), s});
   endtask

   // ---------------- monitor: handshakes observed mid-cycle ----------------
   always @(negedge clk) begin
      logic [15:0] e;
      logic [27:0] ei;
      hs_req = req_ready;
      hs_in  = net_valid_in[0] && (&net_ready_in);
      hs_sum = net_data_in[0] + net_data_in[1];
      hs_out = net_valid_out && net_ready_out;
      if (rst && hs_in) begin
         issue_cnt++;
         last_issue_cyc = cyc;
         if (exp_iss_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_unexpected: got req_ready 0x%0h, expected no issue", req_ready);
         end else begin
            ei = exp_iss_q.pop_front();
            check("issue_grant", 32'(req_ready), 32'(1) << ei[27:24]);
            check("issue_data", 32'({net_data_in[0], net_data_in[1]}), 32'(ei[23:0]));
         end
      end
      if (rst && (|rsp_valid)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_unexpected: got rsp_valid 0x%0h, expected none", rsp_valid);
         end else begin
            e = exp_q[0];
            check("rsp_route", 32'(rsp_valid), 32'(1) << e[15:12]);
            check("rsp_net_ready_out", 32'(net_ready_out), 32'(rsp_ready[e[13:12]]));
            if (hs_out) begin
               void'(exp_q.pop_front());
               rsp_cnt++;
               last_rsp_cyc = cyc;
               check("rsp_data", 32'(rsp_data), 32'(e[11:0]));
            end
         end
      end
   end

   // ---------------- sources and stub network (latency 3, in0+in1) ----------------
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_req[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         end
         if (hs_in) begin
            net_res_q.push_back(hs_sum);
            net_t_q.push_back(cyc - 1);
         end
         if (hs_out && !force_orphan && net_res_q.size() > 0) begin
            void'(net_res_q.pop_front());
            void'(net_t_q.pop_front());
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (src_q[i].size() > 0);
         if (src_q[i].size() > 0) {req_data[i][0], req_data[i][1]} = src_q[i][0];
      end
      stub_valid = 1'b0;
      stub_data  = '0;
      if (net_res_q.size() > 0) begin
         stub_data  = net_res_q[0];
         stub_valid = !net_hold && ((cyc - net_t_q[0]) >= 3);
      end
   end

   // ---------------- directed test sequence ----------------
   initial begin
      int base;
      int rbase;
      int n;
      logic [DW-1:0] a;
      logic [DW-1:0] b;

      rst = 1'b0;
      rsp_ready = '1;
      net_ready_in = 2'b11;
      drain_req = 1'b0;
      force_orphan = 1'b0;
      net_hold = 1'b0;
      stub_valid = 1'b0;
      stub_data = '0;
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data[i][0] = '0;
         req_data[i][1] = '0;
      end
      hs_req = '0;
      hs_in = 1'b0;
      hs_out = 1'b0;
      hs_sum = '0;
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      issue_cnt = 0;
      rsp_cnt = 0;
      last_issue_cyc = 0;
      last_rsp_cyc = 0;

      // Fairness traffic is queued during reset so requests are pending while held.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            a = (r == 0) ? 12'(16 * (i + 1)) : 12'(256 + i);
            b = (r == 0) ? 12'h001 : 12'h0F0;
            add_sample(i, a, b);
         end
      end

      repeat (3) step();
      check("rst_req_valid_pending", 32'(req_valid), 32'hF);
      check("rst_net_valid_in", 32'(net_valid_in), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_net_ready_out", 32'(net_ready_out), 0);
      check("rst_drain_done", 32'(drain_done), 0);
      check("rst_outstanding", 32'(outstanding), 0);
      check("rst_err_orphan", 32'(err_orphan), 0);
      @(posedge clk);
      #2 rst = 1'b1;

      // Fairness: grant order 0,1,2,3,0,1,2,3 with matching responses.
      wait_idle("fair_done", 80);
      repeat (2) step();
      check("fair_outstanding", 32'(outstanding), 0);

      // Single requester: 3-cycle stub latency, routed only to requester 2.
      add_sample(2, 12'h200, 12'h000);
      wait_idle("single_done", 30);
      check("single_latency", 32'(last_rsp_cyc - last_issue_cyc), 3);

      // Full FIFO: stub holds results, exactly TAG_DEPTH issues then stall.
      @(posedge clk);
      #2 net_hold = 1'b1;
      step();
      base = issue_cnt;
      for (int k = 0; k < 8; k++) add_sample(1, 12'(12'h300 + k), 12'(3 * k));
      add_sample(1, 12'hFFF, 12'h002);
      n = 0;
      while (issue_cnt < base + 8 && n < 40) begin
         step();
         n++;
      end
      repeat (4) step();
      check("full_issues", 32'(issue_cnt - base), 8);
      check("full_outstanding", 32'(outstanding), 8);
      check("full_req_ready", 32'(req_ready), 0);
      check("full_net_valid_in", 32'(net_valid_in), 0);
      @(posedge clk);
      #2 net_hold = 1'b0;
      wait_idle("full_release", 60);

      // Backpressure: requester 0 withholds rsp_ready for 5 cycles.
      @(posedge clk);
      #2 rsp_ready = 4'b1110;
      step();
      add_sample(0, 12'h0A5, 12'h05A);
      n = 0;
      while (!rsp_valid[0] && n < 20) begin
         step();
         n++;
      end
      check("bp_rsp_seen", 32'(rsp_valid[0]), 1);
      repeat (5) begin
         check("bp_hold_ready", 32'(net_ready_out), 0);
         check("bp_hold_outstanding", 32'(outstanding), 1);
         step();
      end
      @(posedge clk);
      #2 rsp_ready = '1;
      #1 check("bp_release_ready", 32'(net_ready_out), 1);
      @(posedge clk);
      #2 check("bp_popped", 32'(outstanding), 0);
      wait_idle("bp_done", 10);

      // Drain with 3 outstanding; the issue in the drain_req rising cycle still goes.
      @(posedge clk);
      #2 net_hold = 1'b1;
      step();
      base = issue_cnt;
      rbase = rsp_cnt;
      for (int k = 0; k < 5; k++) add_sample(3, 12'(12'h040 + k), 12'h004);
      n = 0;
      while (issue_cnt < base + 2 && n < 20) begin
         step();
         n++;
      end
      @(posedge clk);
      #2 drain_req = 1'b1;
      repeat (6) step();
      check("drain_issues", 32'(issue_cnt - base), 3);
      check("drain_outstanding", 32'(outstanding), 3);
      check("drain_req_ready", 32'(req_ready), 0);
      check("drain_done_busy", 32'(drain_done), 0);
      check("drain_state", 32'(state_dbg), 32'(ARB_DRAIN));
      @(posedge clk);
      #2 net_hold = 1'b0;
      n = 0;
      while (rsp_cnt < rbase + 3 && n < 20) begin
         step();
         n++;
      end
      check("drain_done_before_last_pop", 32'(drain_done), 0);
      step();
      check("drain_done_set", 32'(drain_done), 1);
      check("drain_no_new_issue", 32'(issue_cnt - base), 3);
      @(posedge clk);
      #2 drain_req = 1'b0;
      wait_idle("drain_resume", 40);
      check("drain_exit_state", 32'(state_dbg), 32'(ARB_RUN));

      // Orphan: result with no tag stalls in the network and sets a sticky flag.
      repeat (3) step();
      check("orphan_clear_before", 32'(err_orphan), 0);
      @(posedge clk);
      #2 force_orphan = 1'b1;
      #1 check("orphan_net_ready_out", 32'(net_ready_out), 0);
      check("orphan_rsp_valid", 32'(rsp_valid), 0);
      @(posedge clk);
      #2 force_orphan = 1'b0;
      repeat (4) step();
      check("orphan_sticky", 32'(err_orphan), 1);

      // Mid-operation asynchronous reset.
      @(posedge clk);
      #2 begin
         net_hold = 1'b1;
         rsp_ready = 4'b1110;
      end
      step();
      base = issue_cnt;
      for (int k = 0; k < 3; k++) add_sample(0, 12'(12'h500 + k), 12'h001);
      n = 0;
      while (issue_cnt < base + 3 && n < 20) begin
         step();
         n++;
      end
      @(posedge clk);
      #2 net_ready_in = 2'b01;
      step();
      src_q[1].push_back({12'h600, 12'h001});
      @(posedge clk);
      #2 net_hold = 1'b0;
      repeat (4) step();
      check("pre_rst_outstanding", 32'(outstanding), 3);
      check("pre_rst_net_valid_in", 32'(net_valid_in), 3);
      check("pre_rst_rsp_valid", 32'(rsp_valid), 1);
      check("pre_rst_err_orphan", 32'(err_orphan), 1);
      #2 rst = 1'b0;
      #1;
      check("arst_net_valid_in", 32'(net_valid_in), 0);
      check("arst_req_ready", 32'(req_ready), 0);
      check("arst_rsp_valid", 32'(rsp_valid), 0);
      check("arst_net_ready_out", 32'(net_ready_out), 0);
      check("arst_drain_done", 32'(drain_done), 0);
      check("arst_outstanding", 32'(outstanding), 0);
      check("arst_err_orphan", 32'(err_orphan), 0);
      check("arst_state", 32'(state_dbg), 32'(ARB_RUN));
      exp_q.delete();
      exp_iss_q.delete();
      for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
      net_res_q.delete();
      net_t_q.delete();
      net_ready_in = 2'b11;
      rsp_ready = '1;
      net_hold = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) step();
      check("post_rst_outstanding", 32'(outstanding), 0);
      check("post_rst_err_orphan", 32'(err_orphan), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
